// File: rtl/trace_unload.sv
// trace_unload: reads words from a trace buffer and shifts them out serially, LSB first.
// Configuration macro: TRACE_UNLOAD_PARITY_EN appends one even-parity bit after each word.
module trace_unload #(
    parameter int Fpay = 32,
    parameter int AW   = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [AW:0]     count,
    output logic            tb_rd,
    input  logic [Fpay-1:0] tb_dout,
    input  logic            shift_en,
    output logic            tdo,
    output logic            tdo_valid,
    output logic            busy,
    output logic            done,
    output logic [AW:0]     words_left
);

`ifdef TRACE_UNLOAD_PARITY_EN
    localparam int NBITS = Fpay + 1;
`else
    localparam int NBITS = Fpay;
`endif
    // Counter must represent NBITS without wrapping inside a word.
    localparam int CW = $clog2(Fpay + 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
    localparam logic [AW:0]   WORDS_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]   WORDS_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        LOAD  = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

`ifdef TRACE_UNLOAD_PARITY_EN
    function automatic logic parity_even(input logic [Fpay-1:0] data);
        return ^data;
    endfunction
`endif

    // Shift-register image of one buffer word (data, plus parity when enabled).
    function automatic logic [NBITS-1:0] load_word(input logic [Fpay-1:0] data);
`ifdef TRACE_UNLOAD_PARITY_EN
        return {parity_even(data), data};
`else
        return data;
`endif
    endfunction

    state_t            state_r, state_s;
    logic [NBITS-1:0]  shreg_r, shreg_s;
    logic [CW-1:0]     bcnt_r, bcnt_s;
    logic [AW:0]       words_r, words_s;
    logic              tb_rd_r, tdo_r, tdo_valid_r, busy_r, done_r;

    // Next-state and datapath update for the unload sequencer.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        bcnt_s  = bcnt_r;
        words_s = words_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    words_s = count;
                    if (count == WORDS_ZERO) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: state_s = WAIT;
            WAIT: state_s = LOAD;
            LOAD: begin
                shreg_s = load_word(tb_dout);
                bcnt_s  = {CW{1'b0}};
                if (words_r != WORDS_ZERO) begin
                    words_s = words_r - WORDS_ONE;
                end else begin
                    words_s = words_r;
                end
                state_s = SHIFT;
            end
            SHIFT: begin
                if (shift_en) begin
                    shreg_s = shreg_r >> 1;
                    bcnt_s  = bcnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (bcnt_r == LAST_BIT) begin
                        if (words_r != WORDS_ZERO) begin
                            state_s = READ;
                        end else begin
                            state_s = DONE;
                        end
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            shreg_r     <= {NBITS{1'b0}};
            bcnt_r      <= {CW{1'b0}};
            words_r     <= WORDS_ZERO;
            tb_rd_r     <= 1'b0;
            tdo_r       <= 1'b0;
            tdo_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shreg_r     <= shreg_s;
            bcnt_r      <= bcnt_s;
            words_r     <= words_s;
            tb_rd_r     <= (state_s == READ);
            tdo_r       <= (state_s == SHIFT) ? shreg_s[0] : 1'b0;
            tdo_valid_r <= (state_s == SHIFT);
            busy_r      <= (state_s == READ) || (state_s == WAIT) ||
                           (state_s == LOAD) || (state_s == SHIFT);
            done_r      <= (state_s == DONE);
        end
    end

    assign tb_rd      = tb_rd_r;
    assign tdo        = tdo_r;
    assign tdo_valid  = tdo_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign words_left = words_r;

endmodule

// File: tb/tb_trace_unload.sv
// Directed bench for trace_unload (Fpay=8, AW=4) with a one-cycle-latency buffer model.
module tb_trace_unload;
    localparam int FPAY = 8;
    localparam int AW   = 4;
`ifdef TRACE_UNLOAD_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int WB = NB + 3;   // cycles per word: READ, WAIT, LOAD, NB shifts

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            shift_en = 1'b0;
    logic [AW:0]     count = '0;
    logic            tb_rd;
    logic [FPAY-1:0] tb_dout;
    logic            tdo, tdo_valid, busy, done;
    logic [AW:0]     words_left;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:15];
    int rd_total = 0;
    int rd_base  = 0;

    logic q_tdo[$], q_val[$], q_done[$], q_busy[$], q_sh[$], bits[$];
    logic [AW:0] q_wl[$];

    always #5 clk = ~clk;

    trace_unload #(.Fpay(FPAY), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .count(count),
        .tb_rd(tb_rd), .tb_dout(tb_dout), .shift_en(shift_en),
        .tdo(tdo), .tdo_valid(tdo_valid), .busy(busy), .done(done),
        .words_left(words_left)
    );

    // Trace buffer model: data appears the cycle after tb_rd and holds.
    always @(posedge clk) begin
        if (tb_rd) begin
            tb_dout  <= mem[(rd_total - rd_base) % 16];
            rd_total <= rd_total + 1;
        end
    end

    function automatic logic exp_bit(input logic [7:0] w, input int i);
        if (i < 8) return w[i];
        return ^w;
    endfunction

    // Runs one unload, recording per-cycle outputs; cycle 0 is the first cycle after acceptance.
    task automatic run_unload(input logic [AW:0] cnt, input bit toggle, input int poke_cyc,
                              input int abort_cyc, output int done_cyc, output int nrd);
        bit sh;
        q_tdo.delete(); q_val.delete(); q_done.delete(); q_busy.delete();
        q_sh.delete(); q_wl.delete(); bits.delete();
        done_cyc = -1;
        rd_base = rd_total;
        @(negedge clk);
        start = 1'b1;
        count = cnt;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == abort_cyc) begin
                reset = 1'b0;
                break;
            end
            sh = toggle ? (c % 2 == 0) : 1'b1;
            shift_en = sh;
            q_tdo.push_back(tdo);
            q_val.push_back(tdo_valid);
            q_done.push_back(done);
            q_busy.push_back(busy);
            q_sh.push_back(sh);
            q_wl.push_back(words_left);
            if (tdo_valid && sh) bits.push_back(tdo);
            if (c == poke_cyc) begin
                start = 1'b1;
                count = 5'd7;
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c == done_cyc + 1) break;
        end
        shift_en = 1'b0;
        start = 1'b0;
        nrd = rd_total - rd_base;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tb_rd, tdo, tdo_valid, busy, done} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000", {tb_rd, tdo, tdo_valid, busy, done});
        end
        checks++;
        if (words_left !== 5'd0) begin
            errors++;
            $display("FAIL reset_words_left: got %0d want 0", words_left);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({tb_rd, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 000", {tb_rd, busy, done});
        end
    endtask

    task automatic test_single();
        int dc, nrd, be;
        mem[0] = 8'hA5;
        run_unload(5'd1, 1'b0, -1, -1, dc, nrd);
        checks++;
        if (nrd !== 1) begin errors++; $display("FAIL single_rd: got %0d want 1", nrd); end
        be = 0;
        for (int i = 0; i < NB; i++) if (i >= bits.size() || bits[i] !== exp_bit(8'hA5, i)) be++;
        checks++;
        if (be !== 0 || bits.size() !== NB) begin
            errors++;
            $display("FAIL single_bits: bad=%0d size=%0d want bad=0 size=%0d", be, bits.size(), NB);
        end
        checks++;
        if (dc !== WB) begin errors++; $display("FAIL single_done_cycle: got %0d want %0d", dc, WB); end
        checks++;
        if (q_busy.size() < 1 || q_busy[0] !== 1'b1) begin
            errors++; $display("FAIL single_busy_start: busy not high after accept");
        end
        checks++;
        if (q_busy.size() < WB + 2 || q_busy[WB + 1] !== 1'b0 || q_done[WB + 1] !== 1'b0) begin
            errors++; $display("FAIL single_after_done: busy/done not low after done");
        end
    endtask

    task automatic test_multi();
        int dc, nrd, be;
        logic [7:0] w [0:2];
        w[0] = 8'h01; w[1] = 8'h80; w[2] = 8'hFF;
        for (int k = 0; k < 3; k++) mem[k] = w[k];
        run_unload(5'd3, 1'b0, -1, -1, dc, nrd);
        checks++;
        if (nrd !== 3) begin errors++; $display("FAIL multi_rd: got %0d want 3", nrd); end
        be = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NB; i++)
                if (k * NB + i >= bits.size() || bits[k * NB + i] !== exp_bit(w[k], i)) be++;
        checks++;
        if (be !== 0 || bits.size() !== 3 * NB) begin
            errors++;
            $display("FAIL multi_bits: bad=%0d size=%0d want bad=0 size=%0d", be, bits.size(), 3 * NB);
        end
        checks++;
        if (q_val.size() < WB + 4 ||
            {q_val[WB - 1], q_val[WB], q_val[WB + 1], q_val[WB + 2], q_val[WB + 3]} !== 5'b10001) begin
            errors++; $display("FAIL multi_gap: tdo_valid gap between words is not 3 cycles");
        end
        checks++;
        if (dc !== 3 * WB) begin errors++; $display("FAIL multi_done_cycle: got %0d want %0d", dc, 3 * WB); end
    endtask

    task automatic test_toggle();
        int dc, nrd, be, nshift, nhold;
        mem[0] = 8'h6B;
        run_unload(5'd1, 1'b1, -1, -1, dc, nrd);
        nshift = 0; nhold = 0;
        for (int c = 0; c + 1 < q_val.size(); c++) begin
            if (q_val[c]) nshift++;
            if (q_val[c] && !q_sh[c] && q_tdo[c + 1] !== q_tdo[c]) nhold++;
        end
        checks++;
        if (nshift !== 2 * NB) begin errors++; $display("FAIL toggle_shift_cycles: got %0d want %0d", nshift, 2 * NB); end
        checks++;
        if (nhold !== 0) begin errors++; $display("FAIL toggle_hold: %0d tdo changes without shift_en, want 0", nhold); end
        be = 0;
        for (int i = 0; i < NB; i++) if (i >= bits.size() || bits[i] !== exp_bit(8'h6B, i)) be++;
        checks++;
        if (be !== 0) begin errors++; $display("FAIL toggle_bits: bad=%0d want 0", be); end
        checks++;
        if (dc !== 3 + 2 * NB) begin errors++; $display("FAIL toggle_done_cycle: got %0d want %0d", dc, 3 + 2 * NB); end
    endtask

    task automatic test_zero_count();
        int dc, nrd, nval;
        run_unload(5'd0, 1'b0, -1, -1, dc, nrd);
        nval = 0;
        foreach (q_val[c]) if (q_val[c]) nval++;
        checks++;
        if (nrd !== 0) begin errors++; $display("FAIL zero_rd: got %0d want 0", nrd); end
        checks++;
        if (dc !== 0) begin errors++; $display("FAIL zero_done_cycle: got %0d want 0", dc); end
        checks++;
        if (nval !== 0) begin errors++; $display("FAIL zero_valid: got %0d valid cycles want 0", nval); end
    endtask

    task automatic test_ignore_start();
        int dc, nrd;
        mem[0] = 8'h12; mem[1] = 8'h34;
        run_unload(5'd2, 1'b0, 5, -1, dc, nrd);
        checks++;
        if (q_wl.size() < 8 || q_wl[6] !== 5'd1 || q_wl[7] !== 5'd1) begin
            errors++; $display("FAIL ignore_words_left: changed after start during SHIFT, want 1");
        end
        checks++;
        if (nrd !== 2) begin errors++; $display("FAIL ignore_rd: got %0d want 2", nrd); end
        checks++;
        if (dc !== 2 * WB) begin errors++; $display("FAIL ignore_done_cycle: got %0d want %0d", dc, 2 * WB); end
    endtask

    task automatic test_reset_mid();
        int dc, nrd, nd, be;
        for (int k = 0; k < 4; k++) mem[k] = 8'hC3;
        run_unload(5'd4, 1'b0, -1, WB + 6, dc, nrd);
        #1;
        checks++;
        if ({tb_rd, tdo, tdo_valid, busy, done} !== 5'b00000 || words_left !== 5'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %b wl=%0d want 00000 wl=0",
                     {tb_rd, tdo, tdo_valid, busy, done}, words_left);
        end
        nd = 0;
        foreach (q_done[c]) if (q_done[c]) nd++;
        repeat (2) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        checks++;
        if (nd !== 0 || nrd !== 2) begin errors++; $display("FAIL abort_no_done: done=%0d rd=%0d want 0 and 2", nd, nrd); end
        reset = 1'b1;
        @(negedge clk);
        mem[0] = 8'h5A;
        run_unload(5'd1, 1'b0, -1, -1, dc, nrd);
        be = 0;
        for (int i = 0; i < NB; i++) if (i >= bits.size() || bits[i] !== exp_bit(8'h5A, i)) be++;
        checks++;
        if (nrd !== 1 || be !== 0 || dc !== WB) begin
            errors++; $display("FAIL after_abort_unload: rd=%0d bad=%0d done=%0d want 1 0 %0d", nrd, be, dc, WB);
        end
    endtask

`ifdef TRACE_UNLOAD_PARITY_EN
    task automatic test_parity();
        int dc, nrd;
        mem[0] = 8'h07; mem[1] = 8'h03;
        run_unload(5'd2, 1'b0, -1, -1, dc, nrd);
        checks++;
        if (bits.size() !== 18 || bits[8] !== 1'b1 || bits[17] !== 1'b0) begin
            errors++; $display("FAIL parity_bits: size=%0d want 18 with parity 1 then 0", bits.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_toggle();
        test_zero_count();
        test_ignore_start();
        test_reset_mid();
`ifdef TRACE_UNLOAD_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
